// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter and single-stage access sequencer for the
// 16x16 data memory. Port 0 is the CPU load/store unit, port 1 the
// debug/DMA loader.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   req/we/addr/wdata{0,1} request channel per port (held until granted)
//   gnt{0,1}              combinational grant for the current cycle
//   rvalid/rdata{0,1}     registered read return, two cycles after grant
//   err{0,1}              registered out-of-range pulse, two cycles after grant
//   dm_addr/dm_wdata/dm_wen  memory drive during the access cycle
//   dm_rdata              combinational read data from memory
//
// Build option: define DM_ARB_CPU_PRIO_EN for fixed port-0 priority with a
// MAX_WAIT starvation limit on port 1; default build is round-robin.
module dm_arbiter #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned MAX_WAIT = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_wen,
    input  logic [DATA_W-1:0] dm_rdata
);

    // The wait counter is 3 bits wide, so the limit must fit in it.
    if (MAX_WAIT < 1 || MAX_WAIT > 7) begin : g_bad_max_wait
        $error("dm_arbiter: MAX_WAIT must be in 1..7");
    end

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    typedef enum logic {IDLE, ACCESS} state_e;

    state_e            state_q, state_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic              err0_q, err0_d, err1_q, err1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              in_range;

    assign in_range = ({1'b0, addr_q} < DEPTH_L);

`ifdef DM_ARB_CPU_PRIO_EN
    logic [2:0] wait_q, wait_d;
    logic       starve;

    assign starve = (wait_q >= 3'(MAX_WAIT));

    // Fixed port-0 priority; a starved port 1 takes the next contended cycle.
    always_comb begin : arb_comb
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        wait_d = wait_q;
        if (!reset) begin
            if (req0 && req1) begin
                gnt1 = starve;
                gnt0 = !starve;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
        if (gnt1) begin
            wait_d = '0;
        end else if (req1 && !starve) begin
            wait_d = wait_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin : wait_reg
        if (reset) wait_q <= '0;
        else       wait_q <= wait_d;
    end
`else
    logic ptr_q, ptr_d;  // port granted most recently

    // Round-robin: under contention the port not granted last wins.
    always_comb begin : arb_comb
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        ptr_d = ptr_q;
        if (!reset) begin
            if (req0 && req1) begin
                gnt1 = !ptr_q;
                gnt0 = ptr_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
        if (gnt0)      ptr_d = 1'b0;
        else if (gnt1) ptr_d = 1'b1;
    end

    always_ff @(posedge clk) begin : ptr_reg
        if (reset) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
    end
`endif

    // Access stage next state, memory drive and completion.
    always_comb begin : access_comb
        state_d   = state_q;
        port_d    = port_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        err0_d    = 1'b0;
        err1_d    = 1'b0;
        rdata0_d  = '0;
        rdata1_d  = '0;
        dm_addr   = '0;
        dm_wdata  = '0;
        dm_wen    = 1'b0;

        if (gnt0 || gnt1) begin
            state_d = ACCESS;
            port_d  = gnt1;
            we_d    = gnt1 ? we1    : we0;
            addr_d  = gnt1 ? addr1  : addr0;
            wdata_d = gnt1 ? wdata1 : wdata0;
        end else begin
            state_d = IDLE;
        end

        if (state_q == ACCESS) begin
            dm_addr  = addr_q;
            dm_wdata = wdata_q;
            // Gated by reset so an access interrupted by reset never commits.
            dm_wen   = we_q && in_range && !reset;
            if (!in_range) begin
                err0_d = !port_q;
                err1_d = port_q;
            end else if (!we_q) begin
                rvalid0_d = !port_q;
                rvalid1_d = port_q;
                if (port_q) rdata1_d = dm_rdata;
                else        rdata0_d = dm_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin : access_reg
        if (reset) begin
            state_q   <= IDLE;
            port_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule
